// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data accesses win, except that a fetch is guaranteed a grant after a bounded data streak.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TmoLast   = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1: data port owns the access
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        discard_q, discard_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        dm_ready_q, dm_ready_d;
  logic        err_q, err_d;

  logic data_req, data_grant, fetch_grant, tmo_done, access_done;

  assign data_req    = dm_rd | dm_wr;
  assign data_grant  = data_req && !(if_req && (streak_q == StreakMax));
  assign fetch_grant = !data_grant && if_req && !if_flush;
  assign tmo_done    = (tmo_q == TmoLast);
  assign access_done = mem_ack || tmo_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (data_grant || fetch_grant) state_d = StWait;
      StWait:  if (access_done) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (!if_req) streak_d = '0;
        if (data_grant) begin
          owner_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_wr;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // A granted data access with a pending fetch implies streak < max, so this saturates.
          if (if_req) streak_d = streak_q + 4'd1;
        end else if (fetch_grant) begin
          owner_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      StWait: begin
        if (if_flush && !owner_q) discard_d = 1'b1;
        if (access_done) begin
          mem_req_d = 1'b0;
          tmo_d     = '0;
          if (!mem_ack) err_d = 1'b1;
          if (owner_q) begin
            dm_rdata_d = mem_ack ? mem_rdata : '0;
            dm_ready_d = 1'b1;
          end else if (!(discard_q || if_flush)) begin
            if_rdata_d = mem_ack ? mem_rdata : '0;
            if_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StResp:  discard_d = 1'b0;
      default: ;
    endcase
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = data_req & ~dm_ready_q;

endmodule
